resp_packetizer: RTL and testbench
==================================

Name: resp_packetizer

Overview:
- Transmit-side counterpart of the command packet parser.
- Takes one ALU/echo result (opcode, up to 8 payload bytes) and serializes it as a response packet toward the UART transmitter.
- Packet format matches the receive side: OPCODE, RESERVED, LEN_LSB, LEN_MSB, then payload bytes in little-endian order.
- LEN is the total packet length in bytes, counting the 4 header frames.

Parameters:
- MAX_BYTES_P, 8, maximum payload bytes per packet; sets the data_i width to 8*MAX_BYTES_P.
- RSV_BYTE_P, 8'h00, value sent in the RESERVED frame.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- opcode_i  input  8  opcode echoed in header byte 0
- data_i  input  8*MAX_BYTES_P  payload; byte 0 = data_i[7:0], sent first
- nbytes_i  input  4  payload byte count, 0..MAX_BYTES_P
- valid_i  input  1  upstream result valid
- ready_o  output  1  block can accept a result
- data_o  output  8  byte to UART TX
- valid_o  output  1  data_o valid
- ready_i  input  1  UART TX accepts byte
- busy_o  output  1  packet in flight

Behaviour:
- Reset and clock: reset rst, synchronous, active-high; clock clk.
- Reset values: state IDLE, ready_o=1, valid_o=0, data_o=0, busy_o=0, counters=0.
- Reset mid-packet: on the next edge valid_o drops and the state returns to IDLE. The partial packet is abandoned with no flush.
- Output timing: ready_o = (state==IDLE). busy_o = !ready_o. data_o and valid_o are driven directly from registers, never combinationally from inputs.
- Accept: when valid_i && ready_o, latch opcode_i, data_i and nbytes_eff = min(nbytes_i, MAX_BYTES_P). Compute len = 4 + nbytes_eff as 16 bits. Go to HDR_OP.
- Latency: valid_o rises on the first edge after the accept, with data_o = opcode.
- Byte handshake: a byte transfers on a cycle with valid_o && ready_i.
  - On transfer, the next byte is loaded on the same edge, so back-to-back bytes are sent at 1 per cycle while ready_i is held high.
  - While valid_o && !ready_i, data_o and valid_o hold stable. valid_o never drops without a transfer, except on reset.
- State sequence, each step advancing on a byte transfer:
  - HDR_OP (data_o = opcode) -> HDR_RSV (RSV_BYTE_P) -> HDR_LSB (len[7:0]) -> HDR_MSB (len[15:8]).
  - From HDR_MSB: if nbytes_eff==0, go to IDLE; else go to PAYLOAD.
  - PAYLOAD: send payload byte k for k = 0..nbytes_eff-1, with the byte counter incrementing per transfer. The transfer of byte nbytes_eff-1 goes to IDLE.
- Packet end: on the final transfer valid_o deasserts on the same edge. ready_o is 1 the following cycle, giving a minimum 1-cycle gap between packets.
- Upstream contract: valid_i while busy is ignored (no accept). Upstream holds valid_i until ready_o.
- Payload order: little-endian. The shift register shifts right by 8 per payload transfer.
- Illegal state: recover to IDLE with valid_o=0.

Decomposition:
- config_pkg additions:
  - resp_state_t enum {R_IDLE, R_HDR_OP, R_HDR_RSV, R_HDR_LSB, R_HDR_MSB, R_PAYLOAD}.
  - HDR_LEN=4.
  - RSV_BYTE default constant.
  - Reuse the existing opcode constants (ECHO, ADD, MUL, DIV).
- Sub-module: shift_out_8, a parallel-in/serial-out register.
  - Inputs: load_i (data), en_i (shift right 8).
  - Output: byte_o = reg[7:0].
  - It is the mirror of the existing shift_8 receive shifter.

Test Plan:
- ADD result: opcode 8'h01 (ADD), data_i=64'h0000_0000_0000_0005, nbytes=4, ready_i=1 -> bytes 01,00,08,00,05,00,00,00 on 8 consecutive cycles; valid_o first high 1 cycle after accept; ready_o high 1 cycle after last byte.
- MUL 8-byte result: data_i=64'h1122334455667788, nbytes=8 -> 02,00,0C,00,88,77,66,55,44,33,22,11.
- Backpressure: same as scenario 1 with ready_i toggled 1,0,0,1... or random -> identical byte sequence; data_o stable during every stall; valid_o never drops before transfer.
- nbytes=0 and nbytes=12 -> 4-byte packet with LEN=0004; clamped packet with LEN=000C and exactly 8 payload bytes.
- valid_i asserted with a different opcode while busy -> ignored; current packet unchanged; second result accepted only after ready_o returns.
- rst asserted after 3 header bytes -> next cycle valid_o=0, ready_o=1; new packet then starts cleanly with its opcode byte.

Source files
------------

// File: rtl/resp_packetizer_pkg.sv
// Shared types and constants for the response packetizer: FSM states, header
// geometry, opcode values and the payload-length clamp.
package resp_packetizer_pkg;

  localparam int         HDR_LEN  = 4;
  localparam logic [7:0] RSV_BYTE = 8'h00;

  localparam logic [7:0] OP_ECHO = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_DIV  = 8'h03;

  typedef enum logic [2:0] {
    R_IDLE,
    R_HDR_OP,
    R_HDR_RSV,
    R_HDR_LSB,
    R_HDR_MSB,
    R_PAYLOAD
  } resp_state_t;

  function automatic logic [3:0] clamp_nbytes(input logic [3:0] n, input logic [3:0] max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/resp_packetizer_if.sv
// Upstream result handshake plus byte stream toward the UART transmitter.
// master = the environment (ALU + UART TX), slave = the packetizer.
interface resp_packetizer_if #(
  parameter int MAX_BYTES_P = 8
);
  logic [7:0]               opcode_i;
  logic [8*MAX_BYTES_P-1:0] data_i;
  logic [3:0]               nbytes_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [7:0]               data_o;
  logic                     valid_o;
  logic                     ready_i;
  logic                     busy_o;

  modport master (
    output opcode_i, data_i, nbytes_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, busy_o
  );

  modport slave (
    input  opcode_i, data_i, nbytes_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, busy_o
  );
endinterface

// File: rtl/resp_packetizer_shift_out_8.sv
// Parallel-in / serial-out byte shifter: loads a whole payload, then presents
// one byte at a time on byte_o, shifting right by 8 per enable.
module resp_packetizer_shift_out_8 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] load_i,
  input  logic         en_i,
  output logic [7:0]   byte_o
);

  logic [W-1:0] sreg_q;

  // NOTE: the data register is reset even though every read follows a load;
  // it keeps byte_o defined after reset and costs nothing on an FPGA flop.
  always_ff @(posedge clk) begin
    if (rst)       sreg_q <= '0;
    else if (ld_i) sreg_q <= load_i;
    else if (en_i) sreg_q <= sreg_q >> 8;
  end

  assign byte_o = sreg_q[7:0];

endmodule

// File: rtl/resp_packetizer.sv
// Serializes one result as OPCODE, RESERVED, LEN_LSB, LEN_MSB, payload (LE)
// toward the UART transmitter; LEN counts the four header bytes.
module resp_packetizer
  import resp_packetizer_pkg::*;
#(
  parameter int         MAX_BYTES_P = 8,
  parameter logic [7:0] RSV_BYTE_P  = RSV_BYTE
) (
  input  logic                 clk,
  input  logic                 rst,
  resp_packetizer_if.slave     bus
);

  resp_state_t state_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic [15:0] len_q;
  logic [3:0]  nbytes_q;
  logic [3:0]  cnt_q;
  logic [7:0]  pay_byte;
  logic [3:0]  nb_eff;
  logic        accept;
  logic        xfer;
  logic        shift_en;

  assign nb_eff   = clamp_nbytes(bus.nbytes_i, 4'(MAX_BYTES_P));
  assign accept   = (state_q == R_IDLE) && bus.valid_i;
  assign xfer     = valid_q && bus.ready_i;
  // The shifter advances on the same edge its low byte is copied into data_q.
  assign shift_en = xfer && ((state_q == R_HDR_MSB) || (state_q == R_PAYLOAD));

  resp_packetizer_shift_out_8 #(.W(8*MAX_BYTES_P)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .ld_i   (accept),
    .load_i (bus.data_i),
    .en_i   (shift_en),
    .byte_o (pay_byte)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= R_IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      len_q    <= '0;
      nbytes_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (bus.valid_i) begin
            data_q   <= bus.opcode_i;
            valid_q  <= 1'b1;
            nbytes_q <= nb_eff;
            len_q    <= 16'(HDR_LEN) + 16'(nb_eff);
            cnt_q    <= '0;
            state_q  <= R_HDR_OP;
          end
        end
        R_HDR_OP: if (xfer) begin
          data_q  <= RSV_BYTE_P;
          state_q <= R_HDR_RSV;
        end
        R_HDR_RSV: if (xfer) begin
          data_q  <= len_q[7:0];
          state_q <= R_HDR_LSB;
        end
        R_HDR_LSB: if (xfer) begin
          data_q  <= len_q[15:8];
          state_q <= R_HDR_MSB;
        end
        R_HDR_MSB: if (xfer) begin
          if (nbytes_q == 4'd0) begin
            valid_q <= 1'b0;
            state_q <= R_IDLE;
          end else begin
            data_q  <= pay_byte;
            state_q <= R_PAYLOAD;
          end
        end
        R_PAYLOAD: if (xfer) begin
          if (cnt_q == nbytes_q - 4'd1) begin
            valid_q <= 1'b0;
            state_q <= R_IDLE;
          end else begin
            data_q <= pay_byte;
            cnt_q  <= cnt_q + 4'd1;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o = (state_q == R_IDLE);
  assign bus.busy_o  = (state_q != R_IDLE);
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_resp_packetizer.sv
// Self-checking bench for resp_packetizer: directed scenarios plus random
// packets under random backpressure, compared against a packet-format model.
module tb_resp_packetizer;
  import resp_packetizer_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  resp_packetizer_if #(.MAX_BYTES_P(8)) bus ();

  resp_packetizer #(.MAX_BYTES_P(8), .RSV_BYTE_P(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Expected packet straight from the wire format: header, then LE payload.
  function automatic byte_q_t model(input logic [7:0] op, input logic [63:0] d, input int nb);
    byte_q_t q;
    int n   = (nb > 8) ? 8 : nb;
    int len = 4 + n;
    q = {};
    q.push_back(op);
    q.push_back(8'h00);
    q.push_back(8'(len % 256));
    q.push_back(8'(len / 256));
    for (int k = 0; k < n; k++) q.push_back(8'((d >> (8 * k)) & 64'hFF));
    return q;
  endfunction

  function automatic bit q_equal(input byte_q_t a, input byte_q_t b);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Waits for ready_o, presents one result for a single accept cycle and
  // returns one cycle after the accept edge.
  task automatic start_packet(input logic [7:0] op, input logic [63:0] d, input int nb,
                              output bit started);
    started = 1'b0;
    for (int c = 0; c < 100 && !started; c++) begin
      if (bus.ready_o === 1'b1) started = 1'b1;
      else begin @(posedge clk); #1; end
    end
    bus.opcode_i = op;
    bus.data_i   = d;
    bus.nbytes_i = 4'(nb);
    bus.valid_i  = 1'b1;
    @(posedge clk); #1;
    bus.valid_i  = 1'b0;
  endtask

  // Drains one packet. mode 0: ready held high, 1: pattern 1,0,0, 2: random.
  task automatic collect(input int mode, output byte_q_t got, output int perr,
                         output int cycles, output bit end_ready, output bit timeout);
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    got = {}; perr = 0; cycles = 0; end_ready = 1'b0; timeout = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (prev_stall && (bus.valid_o !== 1'b1 || bus.data_o !== prev_data)) perr++;
      if (bus.valid_o !== 1'b1) begin
        end_ready = bus.ready_o;
        timeout   = 1'b0;
        break;
      end
      if (bus.busy_o !== 1'b1 || bus.ready_o !== 1'b0) perr++;
      case (mode)
        0:       bus.ready_i = 1'b1;
        1:       bus.ready_i = (c % 3 == 0);
        default: bus.ready_i = 1'($urandom_range(0, 1));
      endcase
      if (bus.ready_i) got.push_back(bus.data_o);
      prev_stall = !bus.ready_i;
      prev_data  = bus.data_o;
      cycles++;
      @(posedge clk); #1;
    end
    bus.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.data_o !== 8'h00)
      $display("FAIL reset: valid=%b ready=%b busy=%b data=%h, need 0 1 0 00",
               bus.valid_o, bus.ready_o, bus.busy_o, bus.data_o);
    else passed++;
  endtask

  // Runs one packet end to end and checks latency, bytes and framing.
  task automatic run_one(input string name, input logic [7:0] op, input logic [63:0] d,
                         input int nb, input int mode);
    byte_q_t got, exp;
    int perr, cyc;
    bit endr, to, st;
    exp = model(op, d, nb);
    start_packet(op, d, nb, st);
    total++;
    if (!st || bus.valid_o !== 1'b1 || bus.data_o !== op)
      $display("FAIL %s latency: started=%b valid=%b data=%h, need 1 1 %h",
               name, st, bus.valid_o, bus.data_o, op);
    else passed++;
    collect(mode, got, perr, cyc, endr, to);
    total++;
    if (!q_equal(got, exp)) $display("FAIL %s bytes: got %p, need %p", name, got, exp);
    else passed++;
    total++;
    if (to || perr != 0 || endr !== 1'b1)
      $display("FAIL %s protocol: timeout=%b errors=%0d ready_after=%b, need 0 0 1",
               name, to, perr, endr);
    else passed++;
    if (mode == 0) begin
      total++;
      if (cyc != exp.size()) $display("FAIL %s cycles: got %0d, need %0d", name, cyc, exp.size());
      else passed++;
    end
  endtask

  task automatic test_add();
    run_one("add", OP_ADD, 64'h0000_0000_0000_0005, 4, 0);
  endtask

  task automatic test_mul8();
    run_one("mul8", OP_MUL, 64'h1122_3344_5566_7788, 8, 0);
  endtask

  task automatic test_backpressure();
    run_one("bp_pattern", OP_ADD, 64'h0000_0000_0000_0005, 4, 1);
    run_one("bp_random", OP_ADD, 64'h0000_0000_0000_0005, 4, 2);
  endtask

  task automatic test_nbytes_edges();
    run_one("nbytes0", OP_ECHO, 64'hDEAD_BEEF_0000_0001, 0, 0);
    run_one("nbytes12", OP_MUL, 64'hA1B2_C3D4_E5F6_0718, 12, 1);
  endtask

  task automatic test_busy_ignore();
    byte_q_t got;
    int perr, cyc;
    bit endr, to, st;
    start_packet(OP_ADD, 64'h0000_0000_0000_AABB, 2, st);
    bus.opcode_i = OP_DIV;
    bus.data_i   = 64'h0000_0000_0000_0077;
    bus.nbytes_i = 4'd1;
    bus.valid_i  = 1'b1;
    collect(0, got, perr, cyc, endr, to);
    total++;
    if (!st || !q_equal(got, model(OP_ADD, 64'hAABB, 2)) || to || perr != 0)
      $display("FAIL busy_first: got %p, need %p (timeout=%b errors=%0d)",
               got, model(OP_ADD, 64'hAABB, 2), to, perr);
    else passed++;
    total++;
    if (endr !== 1'b1) $display("FAIL busy_ready_back: ready_o=%b, need 1", endr);
    else passed++;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    total++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== OP_DIV)
      $display("FAIL busy_second_start: valid=%b data=%h, need 1 %h", bus.valid_o, bus.data_o, OP_DIV);
    else passed++;
    collect(0, got, perr, cyc, endr, to);
    total++;
    if (!q_equal(got, model(OP_DIV, 64'h77, 1)) || to || perr != 0)
      $display("FAIL busy_second: got %p, need %p", got, model(OP_DIV, 64'h77, 1));
    else passed++;
  endtask

  task automatic test_midpacket_reset();
    bit st;
    start_packet(OP_MUL, 64'h1122_3344_5566_7788, 8, st);
    bus.ready_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ready_i = 1'b0;
    total++;
    if (bus.valid_o !== 1'b0) $display("FAIL midrst_valid: valid_o=%b, need 0", bus.valid_o);
    else passed++;
    total++;
    if (bus.ready_o !== 1'b1) $display("FAIL midrst_ready: ready_o=%b, need 1", bus.ready_o);
    else passed++;
    run_one("after_reset", OP_ECHO, 64'h0000_0000_0000_00AB, 1, 0);
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [63:0] d;
    int          nb;
    for (int i = 0; i < 20; i++) begin
      op = 8'($urandom);
      d  = {$urandom, $urandom};
      nb = $urandom_range(0, 15);
      run_one($sformatf("rand%0d", i), op, d, nb, 2);
    end
  endtask

  initial begin
    bus.opcode_i = '0;
    bus.data_i   = '0;
    bus.nbytes_i = '0;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_add();
    test_mul8();
    test_backpressure();
    test_nbytes_edges();
    test_busy_ignore();
    test_midpacket_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
